sqrt2_host_ctrl: RTL and testbench
==================================

Name: sqrt2_host_ctrl

Overview:
Upstream sequencer for the fp16 square-root unit and its shared 16-bit tristate data bus. It accepts fp16 operands from a valid/ready host stream and drives the operand onto the bus with ENABLE asserted. It then releases the bus, waits for the unit's RESULT, samples the result word and the NaN/+Inf/-Inf flags, and returns them on a valid/ready response stream. A timeout guards against a unit that never answers, and a minimum ENABLE-low gap lets the unit reset between operations.

Parameters:
DRIVE_CYCLES, 2, number of CLK cycles the operand is driven on SQ_DATA with SQ_ENABLE high before the bus is released (minimum 1).
SETTLE_CYCLES, 1, cycles to wait after SQ_RESULT is first seen high before SQ_DATA and the flags are sampled (0 means sample on the detection cycle).
GAP_CYCLES, 2, minimum cycles SQ_ENABLE stays low between operations (minimum 2).
TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the operation is aborted.

Ports:
CLK  input  1  clock; all logic is on the rising edge.
RST  input  1  asynchronous, active-high reset.
IN_VALID  input  1  host operand valid.
IN_READY  output  1  controller can accept an operand.
IN_DATA  input  16  fp16 operand.
OUT_VALID  output  1  response valid.
OUT_READY  input  1  host accepts the response.
OUT_DATA  output  16  fp16 result.
OUT_FLAGS  output  3  {is_nan, is_pinf, is_ninf} as returned by the unit.
OUT_TIMEOUT  output  1  response was produced by a timeout abort.
BUSY  output  1  high in every state except IDLE.
SQ_DATA  inout  16  shared bus to the sqrt unit; driven only in LAUNCH, otherwise high-Z.
SQ_ENABLE  output  1  ENABLE input of the sqrt unit.
SQ_RESULT  input  1  RESULT output of the sqrt unit.
SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF  input  1 each  unit flags.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is asynchronous and active-high on RST.
- Reset values: state=IDLE, IN_READY=0 during reset, OUT_VALID=0, OUT_DATA=0, OUT_FLAGS=0, OUT_TIMEOUT=0, BUSY=0, SQ_ENABLE=0, SQ_DATA=high-Z, all counters=0. IN_READY is 1 from the first cycle after RST falls.
- States: IDLE, LAUNCH, WAIT, SETTLE, RESP, GAP.
- IDLE: IN_READY=1. On IN_VALID&IN_READY: latch IN_DATA into op_reg, go to LAUNCH, zero the counter.
- LAUNCH: SQ_ENABLE=1 and SQ_DATA=op_reg for exactly DRIVE_CYCLES cycles, then go to WAIT. SQ_ENABLE stays high through WAIT and SETTLE.
- WAIT: SQ_DATA released (high-Z) from the first WAIT cycle; the controller never drives the bus while the unit may drive it.
  - SQ_RESULT sampled high → SETTLE.
  - Counter reaches TIMEOUT_CYCLES with no SQ_RESULT → load OUT_DATA=16'h7E00, OUT_FLAGS=3'b100, OUT_TIMEOUT=1, drop SQ_ENABLE, go to RESP.
  - If SQ_RESULT and timeout coincide, SQ_RESULT wins.
- SETTLE: wait SETTLE_CYCLES, then load OUT_DATA=SQ_DATA, OUT_FLAGS={SQ_IS_NAN,SQ_IS_PINF,SQ_IS_NINF}, OUT_TIMEOUT=0. Drop SQ_ENABLE on the following cycle and go to RESP. SQ_RESULT falling during SETTLE is ignored.
- RESP: OUT_VALID=1; OUT_DATA, OUT_FLAGS and OUT_TIMEOUT are stable until the handshake. The gap counter runs concurrently from the cycle SQ_ENABLE fell.
  - On OUT_VALID&OUT_READY: OUT_VALID=0 next cycle. Go to IDLE if GAP_CYCLES low cycles have elapsed, else to GAP.
- GAP: SQ_ENABLE=0, IN_READY=0, until the ENABLE-low count reaches GAP_CYCLES, then IDLE.
- Back-to-back operation: the next LAUNCH is never closer than GAP_CYCLES low cycles after the previous ENABLE drop. IN_READY is low in every non-IDLE state.
- Operand latency, no timeout: DRIVE_CYCLES + (cycles until RESULT) + SETTLE_CYCLES + 1 to OUT_VALID.
- Reset mid-operation: SQ_ENABLE falls and the bus tri-states immediately (asynchronous). The response is lost; no OUT_VALID is produced.
- SQ_DATA, SQ_RESULT and the flags are treated as synchronous to CLK; no synchronizers.
- Timeout counter width: clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Operand 16'h4400 (4.0); model unit asserts RESULT 14 cycles after ENABLE with bus=16'h4000 → OUT_DATA=16'h4000, OUT_FLAGS=000, OUT_TIMEOUT=0; SQ_DATA high-Z from cycle DRIVE_CYCLES after launch.
- Operand 16'hBC00 (-1.0); model returns 16'hFE00 with IS_NAN=1 after 3 cycles → OUT_DATA=16'hFE00, OUT_FLAGS=100.
- Model never raises RESULT → after exactly TIMEOUT_CYCLES in WAIT: OUT_DATA=16'h7E00, OUT_FLAGS=100, OUT_TIMEOUT=1, SQ_ENABLE=0.
- Two operands back-to-back with OUT_READY held low 5 cycles on the first → second LAUNCH only after the handshake and at least 2 ENABLE-low cycles; no bus drive overlaps the unit's drive window.
- RST pulsed mid-WAIT → SQ_ENABLE=0 and SQ_DATA=Z on the same edge, OUT_VALID stays 0, IN_READY=1 the cycle after release.
- RESULT asserted on the same cycle the timeout expires → normal capture, OUT_TIMEOUT=0.

Source files
------------

// File: rtl/sqrt2_host_ctrl.sv
// Host-side sequencer for the fp16 square-root unit: launches operands onto the
// shared tristate bus, waits for RESULT (or times out) and returns the response.
module sqrt2_host_ctrl #(
  parameter int DRIVE_CYCLES   = 2,
  parameter int SETTLE_CYCLES  = 1,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] OUT_DATA,
  output logic [2:0]  OUT_FLAGS,
  output logic        OUT_TIMEOUT,
  output logic        BUSY,
  inout  wire  [15:0] SQ_DATA,
  output logic        SQ_ENABLE,
  input  logic        SQ_RESULT,
  input  logic        SQ_IS_NAN,
  input  logic        SQ_IS_PINF,
  input  logic        SQ_IS_NINF
);

  localparam int MAX_DS  = (DRIVE_CYCLES > SETTLE_CYCLES) ? DRIVE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > MAX_DS) ? TIMEOUT_CYCLES : MAX_DS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int GW      = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] DRIVE_LAST   = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    RESP   = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [15:0]    op_q, op_d;
  logic           in_ready_q, in_ready_d;
  logic [15:0]    out_data_q, out_data_d;
  logic [2:0]     out_flags_q, out_flags_d;
  logic           out_timeout_q, out_timeout_d;
  logic           capture;
  logic           gap_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      op_q          <= '0;
      in_ready_q    <= 1'b0;
      out_data_q    <= '0;
      out_flags_q   <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      op_q          <= op_d;
      in_ready_q    <= in_ready_d;
      out_data_q    <= out_data_d;
      out_flags_q   <= out_flags_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  // gap_q counts completed ENABLE-low cycles; done once the current cycle completes the gap
  assign gap_done = (gap_q >= GAP_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    op_d          = op_q;
    out_data_d    = out_data_q;
    out_flags_d   = out_flags_q;
    out_timeout_d = out_timeout_q;
    capture       = 1'b0;

    case (state_q)
      IDLE: begin
        if (IN_VALID && in_ready_q) begin
          op_d    = IN_DATA;
          cnt_d   = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (cnt_q == DRIVE_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        // RESULT is checked first so it beats a timeout expiring on the same cycle
        if (SQ_RESULT) begin
          cnt_d = '0;
          if (SETTLE_CYCLES == 0) begin
            capture = 1'b1;
          end else begin
            state_d = SETTLE;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          out_data_d    = 16'h7E00;
          out_flags_d   = 3'b100;
          out_timeout_d = 1'b1;
          gap_d         = '0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (!gap_done) begin
          gap_d = gap_q + 1'b1;
        end
        if (OUT_READY) begin
          state_d = gap_done ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      out_data_d    = SQ_DATA;
      out_flags_d   = {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF};
      out_timeout_d = 1'b0;
      gap_d         = '0;
      state_d       = RESP;
    end

    in_ready_d = (state_d == IDLE);
  end

  // Decoded straight from the state register so reset drops ENABLE and the bus at once
  assign SQ_ENABLE   = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == SETTLE);
  assign SQ_DATA     = (state_q == LAUNCH) ? op_q : 16'hzzzz;
  assign IN_READY    = in_ready_q;
  assign OUT_VALID   = (state_q == RESP);
  assign BUSY        = (state_q != IDLE);
  assign OUT_DATA    = out_data_q;
  assign OUT_FLAGS   = out_flags_q;
  assign OUT_TIMEOUT = out_timeout_q;

endmodule

// File: tb/tb_sqrt2_host_ctrl.sv
// Directed bench for sqrt2_host_ctrl: a scripted model of the sqrt unit answers
// each launch while hand-computed expectations are asserted cycle by cycle.
module tb_sqrt2_host_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_DATA;
  logic [2:0]  OUT_FLAGS;
  logic        OUT_TIMEOUT;
  logic        BUSY;
  wire  [15:0] sq_data;
  logic        SQ_ENABLE;
  logic        SQ_RESULT;
  logic        SQ_IS_NAN;
  logic        SQ_IS_PINF;
  logic        SQ_IS_NINF;

  logic        unit_drive;
  logic [15:0] unit_data;

  int checks = 0;
  int errors = 0;

  assign sq_data = unit_drive ? unit_data : 16'hzzzz;

  sqrt2_host_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_DATA     (IN_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_DATA    (OUT_DATA),
    .OUT_FLAGS   (OUT_FLAGS),
    .OUT_TIMEOUT (OUT_TIMEOUT),
    .BUSY        (BUSY),
    .SQ_DATA     (sq_data),
    .SQ_ENABLE   (SQ_ENABLE),
    .SQ_RESULT   (SQ_RESULT),
    .SQ_IS_NAN   (SQ_IS_NAN),
    .SQ_IS_PINF  (SQ_IS_PINF),
    .SQ_IS_NINF  (SQ_IS_NINF)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch_op(input logic [15:0] data);
    IN_VALID = 1'b1;
    IN_DATA  = data;
    tick(1);
    IN_VALID = 1'b0;
  endtask

  task automatic unit_respond(input logic [15:0] data, input logic [2:0] flags);
    unit_drive = 1'b1;
    unit_data  = data;
    SQ_RESULT  = 1'b1;
    {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF} = flags;
  endtask

  task automatic unit_idle();
    unit_drive = 1'b0;
    unit_data  = 16'h0000;
    SQ_RESULT  = 1'b0;
    {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF} = 3'b000;
  endtask

  task automatic finish_resp();
    OUT_READY = 1'b1;
    tick(1);
    OUT_READY = 1'b0;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_DATA   = 16'h0000;
    OUT_READY = 1'b0;
    unit_idle();

    // Reset values; the unit model drives a probe pattern to show the DUT is off the bus
    tick(2);
    unit_drive = 1'b1;
    unit_data  = 16'hA5A5;
    #1;
    check("rst_in_ready", IN_READY, 16'h0);
    check("rst_out_valid", OUT_VALID, 16'h0);
    check("rst_busy", BUSY, 16'h0);
    check("rst_enable", SQ_ENABLE, 16'h0);
    check("rst_out_data", OUT_DATA, 16'h0000);
    check("rst_out_flags", OUT_FLAGS, 16'h0);
    check("rst_out_timeout", OUT_TIMEOUT, 16'h0);
    check("rst_bus", sq_data, 16'hA5A5);
    unit_idle();
    tick(1);
    RST = 1'b0;
    tick(1);
    check("post_rst_in_ready", IN_READY, 16'h1);

    // 4.0 -> 2.0, RESULT 14 cycles after ENABLE rises
    launch_op(16'h4400);
    check("t1_enable", SQ_ENABLE, 16'h1);
    check("t1_drive1", sq_data, 16'h4400);
    check("t1_in_ready", IN_READY, 16'h0);
    check("t1_busy", BUSY, 16'h1);
    tick(1);
    check("t1_drive2", sq_data, 16'h4400);
    tick(1);
    unit_drive = 1'b1;
    unit_data  = 16'h1234;
    #1;
    check("t1_release", sq_data, 16'h1234);
    check("t1_wait_enable", SQ_ENABLE, 16'h1);
    unit_idle();
    tick(11);
    check("t1_no_valid_yet", OUT_VALID, 16'h0);
    unit_respond(16'h4000, 3'b000);
    tick(1);
    check("t1_settle_valid", OUT_VALID, 16'h0);
    check("t1_settle_enable", SQ_ENABLE, 16'h1);
    tick(1);
    check("t1_valid", OUT_VALID, 16'h1);
    check("t1_data", OUT_DATA, 16'h4000);
    check("t1_flags", OUT_FLAGS, 16'h0);
    check("t1_timeout", OUT_TIMEOUT, 16'h0);
    check("t1_enable_drop", SQ_ENABLE, 16'h0);
    unit_idle();
    tick(1);
    check("t1_hold_valid", OUT_VALID, 16'h1);
    check("t1_hold_data", OUT_DATA, 16'h4000);
    finish_resp();
    check("t1_done_valid", OUT_VALID, 16'h0);
    check("t1_done_ready", IN_READY, 16'h1);

    // -1.0 -> NaN, immediate handshake forces a GAP cycle
    launch_op(16'hBC00);
    tick(3);
    unit_respond(16'hFE00, 3'b100);
    tick(1);
    check("t2_settle_valid", OUT_VALID, 16'h0);
    tick(1);
    check("t2_valid", OUT_VALID, 16'h1);
    check("t2_data", OUT_DATA, 16'hFE00);
    check("t2_flags", OUT_FLAGS, 16'h4);
    check("t2_timeout", OUT_TIMEOUT, 16'h0);
    unit_idle();
    OUT_READY = 1'b1;
    tick(1);
    OUT_READY = 1'b0;
    check("t2_gap_valid", OUT_VALID, 16'h0);
    check("t2_gap_ready", IN_READY, 16'h0);
    check("t2_gap_busy", BUSY, 16'h1);
    check("t2_gap_enable", SQ_ENABLE, 16'h0);
    tick(1);
    check("t2_idle_ready", IN_READY, 16'h1);
    check("t2_idle_busy", BUSY, 16'h0);

    // Unit never answers: abort after exactly 64 WAIT cycles
    launch_op(16'h3C00);
    tick(2);
    tick(63);
    check("t3_last_wait_valid", OUT_VALID, 16'h0);
    check("t3_last_wait_enable", SQ_ENABLE, 16'h1);
    tick(1);
    check("t3_valid", OUT_VALID, 16'h1);
    check("t3_data", OUT_DATA, 16'h7E00);
    check("t3_flags", OUT_FLAGS, 16'h4);
    check("t3_timeout", OUT_TIMEOUT, 16'h1);
    check("t3_enable", SQ_ENABLE, 16'h0);
    finish_resp();
    check("t3_done_ready", IN_READY, 16'h1);

    // RESULT on the final WAIT cycle beats the timeout
    launch_op(16'h4C00);
    tick(2);
    tick(63);
    unit_respond(16'h7C00, 3'b010);
    tick(1);
    check("t6_no_abort_valid", OUT_VALID, 16'h0);
    check("t6_settle_enable", SQ_ENABLE, 16'h1);
    tick(1);
    check("t6_valid", OUT_VALID, 16'h1);
    check("t6_data", OUT_DATA, 16'h7C00);
    check("t6_flags", OUT_FLAGS, 16'h2);
    check("t6_timeout", OUT_TIMEOUT, 16'h0);
    unit_idle();
    finish_resp();

    // Back-to-back: second operand waits through a 5-cycle stalled response
    launch_op(16'h5400);
    tick(2);
    unit_respond(16'h4800, 3'b000);
    tick(2);
    check("t4a_valid", OUT_VALID, 16'h1);
    check("t4a_data", OUT_DATA, 16'h4800);
    unit_idle();
    IN_VALID = 1'b1;
    IN_DATA  = 16'h4400;
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_valid", OUT_VALID, 16'h1);
      check("t4_stall_ready", IN_READY, 16'h0);
      check("t4_stall_enable", SQ_ENABLE, 16'h0);
      tick(1);
    end
    OUT_READY = 1'b1;
    tick(1);
    OUT_READY = 1'b0;
    check("t4_hs_valid", OUT_VALID, 16'h0);
    check("t4_hs_enable", SQ_ENABLE, 16'h0);
    check("t4_hs_ready", IN_READY, 16'h1);
    tick(1);
    IN_VALID = 1'b0;
    check("t4b_enable", SQ_ENABLE, 16'h1);
    check("t4b_drive1", sq_data, 16'h4400);
    tick(1);
    check("t4b_drive2", sq_data, 16'h4400);
    tick(1);
    unit_respond(16'h4000, 3'b000);
    #1;
    check("t4b_release", sq_data, 16'h4000);
    tick(2);
    check("t4b_valid", OUT_VALID, 16'h1);
    check("t4b_data", OUT_DATA, 16'h4000);
    unit_idle();
    finish_resp();

    // Reset pulsed mid-WAIT drops ENABLE asynchronously and loses the response
    launch_op(16'h4400);
    tick(5);
    check("t5_wait_enable", SQ_ENABLE, 16'h1);
    #2;
    RST = 1'b1;
    #1;
    check("t5_async_enable", SQ_ENABLE, 16'h0);
    check("t5_async_busy", BUSY, 16'h0);
    check("t5_async_valid", OUT_VALID, 16'h0);
    check("t5_async_ready", IN_READY, 16'h0);
    unit_respond(16'h4000, 3'b000);
    #1;
    check("t5_async_bus", sq_data, 16'h4000);
    tick(1);
    RST = 1'b0;
    check("t5_release_ready", IN_READY, 16'h0);
    tick(1);
    check("t5_ready_after", IN_READY, 16'h1);
    unit_idle();
    tick(3);
    check("t5_lost_valid", OUT_VALID, 16'h0);
    check("t5_lost_busy", BUSY, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
